// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S serial audio blocks.
package i2s_pkg;

    localparam int unsigned MODE_I2S = 0;
    localparam int unsigned MODE_LJ  = 1;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides the system clock and flags each bclk edge one cycle early.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned DivFactor = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic bclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = clog2(DivFactor + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DivFactor);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] div_cnt_d, div_cnt_q;
    logic            bclk_d, bclk_q;
    logic            wrap;

    always_comb begin
        wrap      = (div_cnt_q == CntMax);
        div_cnt_d = wrap ? CntOne : div_cnt_q + CntOne;
        bclk_d    = wrap ? !bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= CntOne;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Strobes mark the sysclk edge on which bclk is about to toggle.
    assign bclk_o = bclk_q;
    assign rise_o = wrap && !bclk_q;
    assign fall_o = wrap && bclk_q;

endmodule

// File: rtl/i2s_tx_framed.sv
// Stereo I2S / left-justified transmitter with a one-pair holding buffer and underrun flag.
module i2s_tx_framed
    import i2s_pkg::*;
#(
    parameter int unsigned DIV_FACTOR = 3,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 16,
    parameter int unsigned MODE       = 0
) (
    input  logic                sysclk_i,
    input  logic                rst_ni,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [SAMPLE_W-1:0] s_left_i,
    input  logic [SAMPLE_W-1:0] s_right_i,
    output logic                bclk_o,
    output logic                wclk_o,
    output logic                dout_o,
    output logic                frame_start_o,
    output logic                underrun_o
);

    localparam int unsigned FrameW = 2 * SLOT_W;
    localparam int unsigned PosW   = clog2(FrameW);
    localparam logic [PosW-1:0] PosLast   = PosW'(FrameW - 1);
    localparam logic [PosW-1:0] PosSlot   = PosW'(SLOT_W);
    localparam logic [PosW-1:0] PosSlotM1 = PosW'(SLOT_W - 1);
    localparam logic [PosW-1:0] PosOne    = PosW'(1);

    logic                bit_fall;
    logic                unused_bclk_rise;
    logic                accept, load;
    logic [FrameW-1:0]   buf_frame, frame;
    logic [FrameW-1:0]   shift_d, shift_q;
    logic [PosW-1:0]     pos_d, pos_q;
    logic [SAMPLE_W-1:0] buf_l_d, buf_l_q, buf_r_d, buf_r_q;
    logic                full_d, full_q;
    logic                dout_d, dout_q, wclk_d, wclk_q;
    logic                frame_start_d, frame_start_q, underrun_d, underrun_q;

    i2s_bclk_gen #(
        .DivFactor(DIV_FACTOR)
    ) u_bclk_gen (
        .clk_i (sysclk_i),
        .rst_ni(rst_ni),
        .bclk_o(bclk_o),
        .rise_o(unused_bclk_rise),
        .fall_o(bit_fall)
    );

    // Each slot is MSB-aligned; unused low slot bits go out as zero.
    assign buf_frame = (FrameW'(buf_l_q) << (FrameW - SAMPLE_W))
                     | (FrameW'(buf_r_q) << (SLOT_W - SAMPLE_W));

    always_comb begin
        accept        = s_valid_i && !full_q;
        load          = bit_fall && (pos_q == PosLast);
        frame         = shift_q;
        pos_d         = pos_q;
        shift_d       = shift_q;
        dout_d        = dout_q;
        wclk_d        = wclk_q;
        full_d        = full_q;
        buf_l_d       = buf_l_q;
        buf_r_d       = buf_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (bit_fall) begin
            pos_d   = load ? '0 : pos_q + PosOne;
            frame   = load ? (full_q ? buf_frame : '0) : shift_q;
            dout_d  = frame[FrameW-1];
            shift_d = frame << 1;
            // I2S switches the word clock one bit ahead of the slot it names.
            if (MODE == MODE_I2S) begin
                wclk_d = (pos_d >= PosSlotM1) && (pos_d != PosLast);
            end else begin
                wclk_d = (pos_d >= PosSlot);
            end
        end

        if (load) begin
            frame_start_d = 1'b1;
            underrun_d    = !full_q;
            full_d        = 1'b0;
        end

        if (accept) begin
            full_d  = 1'b1;
            buf_l_d = s_left_i;
            buf_r_d = s_right_i;
        end
    end

    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q         <= PosLast;
            shift_q       <= '0;
            dout_q        <= 1'b0;
            wclk_q        <= 1'b0;
            full_q        <= 1'b0;
            buf_l_q       <= '0;
            buf_r_q       <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            shift_q       <= shift_d;
            dout_q        <= dout_d;
            wclk_q        <= wclk_d;
            full_q        <= full_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign s_ready_o     = !full_q;
    assign wclk_o        = wclk_q;
    assign dout_o        = dout_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

endmodule
